// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory write port; big-endian words.
// Optional trailer checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [LEN_BITS-1:0]  length,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_din,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_FINISH,
    S_CHECK
  } state_t;

  state_t               state_q;
  logic [1:0]           cnt_q;
  logic [LEN_BITS-1:0]  idx_q;
  logic [LEN_BITS-1:0]  len_q;
  logic [ADDR_BITS-1:0] base_q;
  logic [23:0]          word_q;
  logic                 rdy_q;
  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DATA_BITS-1:0] din_q;
  logic                 hold_q;
  logic                 done_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           sum_q;
  logic                 err_q;
`endif

  logic take;
  logic last;
  assign take = in_valid && rdy_q;
  assign last = (idx_q + LEN_BITS'(1)) == len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      word_q  <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            len_q  <= length;
            idx_q  <= '0;
            cnt_q  <= '0;
            word_q <= '0;
            hold_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_q  <= '0;
            err_q  <= 1'b0;
            // empty load still expects the trailer byte
            if (length == '0) begin
              state_q <= S_CHECK;
              rdy_q   <= 1'b1;
            end else begin
              state_q <= S_COLLECT;
              rdy_q   <= 1'b1;
            end
`else
            if (length == '0) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_COLLECT;
              rdy_q   <= 1'b1;
            end
`endif
          end
        end
        S_COLLECT: begin
          if (take) begin
            word_q <= {word_q[15:0], in_data};
            cnt_q  <= cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_q  <= sum_q + in_data;
`endif
            if (cnt_q == 2'd3) begin
              state_q <= S_WRITE;
              rdy_q   <= 1'b0;
              we_q    <= 1'b1;
              addr_q  <= base_q + idx_q[ADDR_BITS-1:0];
              din_q   <= {word_q, in_data};
            end
          end
        end
        S_WRITE: begin
          idx_q <= idx_q + LEN_BITS'(1);
          cnt_q <= '0;
          if (last) begin
`ifdef LOADER_CHECKSUM_EN
            state_q <= S_CHECK;
            rdy_q   <= 1'b1;
`else
            state_q <= S_FINISH;
            done_q  <= 1'b1;
`endif
          end else begin
            state_q <= S_COLLECT;
            rdy_q   <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (take) begin
            if (sum_q + in_data != 8'd0) err_q <= 1'b1;
            rdy_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FINISH;
          end
        end
`endif
        S_FINISH: begin
          hold_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b0;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = rdy_q;
  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign cpu_hold = hold_q;
  assign busy     = hold_q;
  assign done     = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign error    = err_q;
`else
  assign error    = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: word-level model of expected writes and timing,
// directed loads with literal pins on addresses, data and cycle offsets.
module tb_imem_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] length;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  int checks = 0;
  int errs = 0;
  int cyc = 0;
  int hold_lo = 0;
  int hold_hi = -1;
  int exp_done = -1;
  int t0 = 0;
  int done_cyc = -1;
  int done_cnt = 0;
  int wr_cnt = 0;
  bit chk_on = 0;
  wr_t expq[$];
  logic [7:0] bq[$];
  int log_cyc[$];
  logic [9:0] log_a[$];
  logic [31:0] log_d[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  // per-cycle comparison against the word-level model
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      automatic bit hold_e = (cyc >= hold_lo) && (cyc <= hold_hi);
      chk("cpu_hold", cpu_hold, hold_e);
      chk("busy", busy, hold_e);
      if (!hold_e) chk("in_ready_idle", in_ready, 0);
      chk("done", done, cyc == exp_done);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_we) begin
        if (expq.size() == 0) begin
          chk("we_unexpected", mem_we, 0);
        end else begin
          automatic wr_t w = expq.pop_front();
          chk("mem_addr", mem_addr, w.a);
          chk("mem_din", mem_din, w.d);
          wr_cnt++;
          log_cyc.push_back(cyc - t0);
          log_a.push_back(mem_addr);
          log_d.push_back(mem_din);
        end
      end
`ifndef LOADER_CHECKSUM_EN
      chk("error_zero", error, 0);
`endif
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("in_ready_timeout", in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_load(input logic [9:0] b, input int n,
                          input int stall_at, input int stall_n,
                          input int abort_at, input int tr);
    logic [7:0] sum;
    logic [7:0] trb;
    int dc0;
    int g;
    wr_t w;
    sum = 8'd0;
    for (int i = 0; i < n; i++) begin
      w.a = b + 10'(i);
      w.d = {bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]};
      expq.push_back(w);
      for (int k = 0; k < 4; k++) sum = sum + bq[4*i+k];
    end
    trb = (tr < 0) ? 8'(8'd0 - sum) : tr[7:0];
    log_cyc.delete();
    log_a.delete();
    log_d.delete();
    dc0 = done_cnt;
    @(posedge clk);
    #1;
    t0 = cyc;
    hold_lo = cyc + 1;
    if (abort_at >= 0) begin
      exp_done = -1;
      hold_hi = 1 << 30;
    end else begin
      exp_done = cyc + 5 * n + 1 + stall_n + CHK;
      hold_hi = exp_done;
    end
    start = 1'b1;
    base_addr = b;
    length = n[10:0];
    @(posedge clk);
    #1;
    start = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    chk("error_clear_on_start", error, 0);
`endif
    for (int k = 0; k < 4 * n; k++) begin
      if (k == abort_at) break;
      send_byte(bq[k]);
      if (k + 1 == stall_at) begin
        repeat (stall_n) @(posedge clk);
        #1;
      end
    end
    if (abort_at >= 0) begin
      hold_hi = -1;
      expq.delete();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt - dc0, 0);
    end else begin
`ifdef LOADER_CHECKSUM_EN
      send_byte(trb);
`endif
      g = 0;
      while (cyc <= exp_done + 1 && g < 400) begin
        @(posedge clk);
        g++;
      end
      #1;
      chk("queue_empty", expq.size(), 0);
      chk("done_count", done_cnt - dc0, 1);
    end
  endtask

  task automatic check_reset_state();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_din, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_on = 1;
    check_reset_state();
    repeat (20) @(posedge clk);
    #1;

    bq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_load(10'h010, 2, -1, 0, -1, -1);
    chk("a_nwr", log_cyc.size(), 2);
    if (log_cyc.size() == 2) begin
      chk("a_cyc0", log_cyc[0], 5);
      chk("a_addr0", log_a[0], 10'h010);
      chk("a_data0", log_d[0], 32'h12345678);
      chk("a_cyc1", log_cyc[1], 10);
      chk("a_addr1", log_a[1], 10'h011);
      chk("a_data1", log_d[1], 32'h9ABCDEF0);
    end
    chk("a_done_cyc", done_cyc - t0, 11 + CHK);

    run_load(10'h010, 2, 2, 7, -1, -1);
    chk("b_nwr", log_cyc.size(), 2);
    if (log_cyc.size() == 2) begin
      chk("b_cyc0", log_cyc[0], 12);
      chk("b_data0", log_d[0], 32'h12345678);
      chk("b_cyc1", log_cyc[1], 17);
      chk("b_data1", log_d[1], 32'h9ABCDEF0);
    end
    chk("b_done_cyc", done_cyc - t0, 18 + CHK);

    bq = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    run_load(10'h3FF, 2, -1, 0, -1, -1);
    chk("w_nwr", log_a.size(), 2);
    if (log_a.size() == 2) begin
      chk("w_addr0", log_a[0], 10'h3FF);
      chk("w_addr1", log_a[1], 10'h000);
      chk("w_data1", log_d[1], 32'hA4A5A6A7);
    end

    bq.delete();
    run_load(10'h055, 0, -1, 0, -1, -1);
    chk("z_nwr", log_a.size(), 0);
    chk("z_done_cyc", done_cyc - t0, 1 + CHK);

    bq.delete();
    for (int i = 0; i < 16; i++) bq.push_back(8'(8'h30 + i));
    run_load(10'h040, 4, -1, 0, 6, -1);
    chk("r_nwr", log_a.size(), 1);
    if (log_a.size() == 1) begin
      chk("r_addr0", log_a[0], 10'h040);
      chk("r_data0", log_d[0], 32'h30313233);
    end
    check_reset_state();

    bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_load(10'h020, 1, -1, 0, -1, -1);
    chk("p_nwr", log_a.size(), 1);
    if (log_a.size() == 1) begin
      chk("p_addr0", log_a[0], 10'h020);
      chk("p_data0", log_d[0], 32'hDEADBEEF);
    end

`ifdef LOADER_CHECKSUM_EN
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(10'h100, 1, -1, 0, -1, 8'hF6);
    chk("cs_good_err", error, 0);
    run_load(10'h100, 1, -1, 0, -1, 8'hF5);
    chk("cs_bad_err", error, 1);
    run_load(10'h104, 1, -1, 0, -1, -1);
    chk("cs_after_err", error, 0);
`endif

    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side companion to the pipeline's read-only instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word into the memory's write port at consecutive word addresses from a programmable base.
- Holds the CPU off (cpu_hold) while a load is in progress and pulses done on completion.

Parameters:
- ADDR_BITS, 10, word-address width of the target memory.
- DATA_BITS, 32, word width; fixed at 32 (4 bytes per word).
- LEN_BITS, 11, width of the word-count input; must allow 2^ADDR_BITS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  ADDR_BITS  first word address; captured on accepted start.
- length  input  LEN_BITS  number of words to write; captured on accepted start.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  write strobe to the memory, one cycle per word.
- mem_addr  output  ADDR_BITS  word address for the write.
- mem_din  output  DATA_BITS  word to write.
- cpu_hold  output  1  high whenever state is not IDLE.
- busy  output  1  same as cpu_hold; kept separate for status readback.
- done  output  1  one-cycle pulse at the end of a load.
- error  output  1  sticky checksum mismatch flag (see Optional Feature); otherwise 0.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All outputs 0: in_ready, mem_we, mem_addr, mem_din, cpu_hold, busy, done, error.
  - Byte counter, word index and assembly register cleared.
- Reset mid-load: the load is abandoned, any partial word is discarded, nothing further is written.
- States: IDLE, COLLECT, WRITE, FINISH (plus CHECK when the optional feature is built in).
- IDLE:
  - On start=1: capture base_addr and length; clear word index, byte counter and error.
  - length==0 -> FINISH; otherwise -> COLLECT.
  - start=0 -> stay in IDLE.
- COLLECT:
  - in_ready=1.
  - Byte accepted when in_valid && in_ready.
  - Byte k of a word (k=0..3) goes to bits [31-8k : 24-8k]; first byte is the MSB.
  - Accepting the 4th byte -> WRITE next cycle.
  - in_valid low -> wait indefinitely; no timeout.
- WRITE:
  - Exactly one cycle; in_ready=0; mem_we=1.
  - mem_addr = (base + index) mod 2^ADDR_BITS; the address wraps silently.
  - mem_din = assembled word.
  - Then index+1. If index was length-1 -> FINISH (or CHECK), else -> COLLECT with byte counter reset.
- FINISH: done=1 for exactly one cycle -> IDLE. cpu_hold drops on the same edge that leaves FINISH.
- Latency:
  - A word is written in the cycle after its 4th byte is accepted.
  - Peak throughput is 4 bytes per 5 cycles.
  - A total of N words with continuous in_valid completes in 5N+2 cycles, counted from start to the done pulse inclusive.
- start while not IDLE: ignored. Bytes presented while in_ready=0: not consumed.
- mem_we is never asserted outside WRITE. mem_addr and mem_din hold their last values between writes.
- length > 2^ADDR_BITS: addresses wrap and earlier words are overwritten. This is legal and not flagged.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) is kept over all data bytes of the load.
  - After the last WRITE, the state goes to CHECK with in_ready=1 and waits for one extra byte.
  - The extra byte is accepted when in_valid=1. If sum + byte != 0 (mod 256), error is set. error stays set until the next accepted start or reset.
  - Then FINISH.
  - length==0 also passes through CHECK; the sum is 0, so the expected byte is 0x00.
- Not defined: no CHECK state, no sum register, error tied to 0, and the load ends immediately after the last WRITE.

Test Plan:
- Reset then idle: rst pulse, no start -> all outputs 0 and in_ready=0 for 20 cycles.
- Two-word load: start with base=0x010, length=2, bytes 12 34 56 78 9A BC DE F0 sent back to back.
  - Write 1: mem_we at 0x010 with 0x12345678. Write 2: at 0x011 with 0x9ABCDEF0.
  - done pulses once, 12 cycles after start; cpu_hold high from the cycle after start through done.
- Stalled stream: same load with in_valid low for 7 cycles between bytes 2 and 3 -> identical writes, no extra mem_we, done delayed by 7 cycles.
- Wrap and zero length:
  - base=0x3FF, length=2 -> writes at 0x3FF then 0x000.
  - length=0 -> done pulse with no mem_we.
- Reset mid-load: assert rst after 6 bytes of a length=4 load -> exactly one write (word 0), immediate IDLE, no done. A following start with base=0x020, length=1 works normally.
- LOADER_CHECKSUM_EN: bytes 01 02 03 04 then 0xF6 -> error=0. Repeat with trailer 0xF5 -> error=1, done still pulses, and error clears on the next start.
